// File: rtl/gfx_rom_arb_pkg.sv
// ============================================================================
// Module   : gfx_rom_arb_pkg
// Brief    : Shared types and constants for the graphics ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gfx_rom_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int REQ_A   = 0;
    localparam int REQ_B   = 1;
    localparam int REQ_F   = 2;
    localparam int NUM_REQ = 3;

    localparam int ADDR_W_DEFAULT = 18;
    localparam int DATA_W_DEFAULT = 32;

    // Pointer value that makes layer A the first candidate.
    localparam logic [1:0] c_ptr_reset = 2'd2;

    function automatic logic [1:0] f_grant_idx(input logic [NUM_REQ-1:0] grant);
        logic [1:0] idx;
        idx = 2'd0;
        if (grant[REQ_B]) idx = 2'd1;
        if (grant[REQ_F]) idx = 2'd2;
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gfx_rom_arb_prio.sv
// ============================================================================
// Module   : gfx_rom_arb_prio
// Brief    : Combinational rotating grant selector; search starts after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gfx_rom_arb_prio
    import gfx_rom_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant
);

    // ptr=2 yields plain A > B > F, which is how the fixed build reuses this.
    always_comb begin
        grant = '0;
        case (ptr)
            2'd0: begin
                if (req[REQ_B])      grant[REQ_B] = 1'b1;
                else if (req[REQ_F]) grant[REQ_F] = 1'b1;
                else if (req[REQ_A]) grant[REQ_A] = 1'b1;
            end
            2'd1: begin
                if (req[REQ_F])      grant[REQ_F] = 1'b1;
                else if (req[REQ_A]) grant[REQ_A] = 1'b1;
                else if (req[REQ_B]) grant[REQ_B] = 1'b1;
            end
            default: begin
                if (req[REQ_A])      grant[REQ_A] = 1'b1;
                else if (req[REQ_B]) grant[REQ_B] = 1'b1;
                else if (req[REQ_F]) grant[REQ_F] = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/gfx_rom_arbiter.sv
// ============================================================================
// Module   : gfx_rom_arbiter
// Brief    : Three-requester arbiter for a shared async graphics ROM pair.
//            Define GFX_ROM_ARB_RR_EN for round-robin grant (default: fixed).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gfx_rom_arbiter
    import gfx_rom_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int DATA_W      = DATA_W_DEFAULT
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [NUM_REQ-1:0]  REQ,
    input  logic [ADDR_W-1:0]   ADDR_A,
    input  logic [ADDR_W-1:0]   ADDR_B,
    input  logic [ADDR_W-1:0]   ADDR_F,
    output logic [NUM_REQ-1:0]  ACK,
    output logic [DATA_W-1:0]   RDATA,
    output logic [ADDR_W-1:0]   ROM_ADDR,
    output logic                ROM_CEn,
    output logic                ROM_OEn,
    input  logic [DATA_W-1:0]   ROM_DATA
);

    localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   w_grant;
    logic [1:0]           w_ptr;
    logic [3:0]           r_wait;
    logic [ADDR_W-1:0]    r_rom_addr;
    logic [ADDR_W-1:0]    w_addr_sel;
    logic [DATA_W-1:0]    r_rdata;
    logic                 w_take;
    logic                 w_capture;

`ifdef GFX_ROM_ARB_RR_EN
    logic [1:0] r_ptr;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_ptr <= c_ptr_reset;
        end else if (w_take) begin
            r_ptr <= f_grant_idx(w_grant);
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = c_ptr_reset;
`endif

    gfx_rom_arb_prio u_prio (
        .req   (REQ),
        .ptr   (w_ptr),
        .grant (w_grant)
    );

    always_comb begin
        w_addr_sel = ADDR_A;
        if (w_grant[REQ_B]) w_addr_sel = ADDR_B;
        if (w_grant[REQ_F]) w_addr_sel = ADDR_F;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ROM_CEn     = 1'b1;
        ROM_OEn     = 1'b1;
        ACK         = '0;
        w_take      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|REQ) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ROM_CEn     = 1'b0;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                ROM_CEn = 1'b0;
                ROM_OEn = 1'b0;
                if (r_wait == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ACK         = r_grant;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant and address are frozen at IDLE so requester changes mid-access are ignored.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_grant    <= '0;
            r_rom_addr <= '0;
            r_wait     <= 4'd0;
            r_rdata    <= '0;
        end else begin
            if (w_take) begin
                r_grant    <= w_grant;
                r_rom_addr <= w_addr_sel;
            end
            if (r_state == ST_SETUP) begin
                r_wait <= c_wait_load;
            end else if ((r_state == ST_ACCESS) && (r_wait != 4'd0)) begin
                r_wait <= r_wait - 4'd1;
            end
            if (w_capture) begin
                r_rdata <= ROM_DATA;
            end
        end
    end

    assign ROM_ADDR = r_rom_addr;
    assign RDATA    = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_gfx_rom_arbiter.sv
// ============================================================================
// Module   : tb_gfx_rom_arbiter
// Brief    : Scoreboard bench for gfx_rom_arbiter (WAIT_CYCLES=4 and =1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gfx_rom_arbiter;

    localparam int W = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic [2:0]  req;
    logic [17:0] addr_a, addr_b, addr_f;
    logic [2:0]  ack;
    logic [31:0] rdata, rom_data;
    logic [17:0] rom_addr;
    logic        rom_cen, rom_oen;

    logic [2:0]  req1;
    logic [17:0] addr1;
    logic [2:0]  ack1;
    logic [31:0] rdata1, rom_data1;
    logic [17:0] rom_addr1;
    logic        cen1, oen1;

    int cyc     = 0;
    int oen_cnt = 0;
    int n_chk   = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  ack;
        logic [17:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    function automatic logic [31:0] rom_word(input logic [17:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0] ^ 16'h1E1E};
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void expect_acc(input logic [2:0] a, input logic [17:0] ad);
        q.push_back('{a, ad, rom_word(ad)});
    endfunction

    gfx_rom_arbiter #(.WAIT_CYCLES(W), .ADDR_W(18), .DATA_W(32)) u_dut (
        .CLK(clk), .RSTn(rstn), .REQ(req),
        .ADDR_A(addr_a), .ADDR_B(addr_b), .ADDR_F(addr_f),
        .ACK(ack), .RDATA(rdata), .ROM_ADDR(rom_addr),
        .ROM_CEn(rom_cen), .ROM_OEn(rom_oen), .ROM_DATA(rom_data)
    );

    gfx_rom_arbiter #(.WAIT_CYCLES(1), .ADDR_W(18), .DATA_W(32)) u_dut1 (
        .CLK(clk), .RSTn(rstn), .REQ(req1),
        .ADDR_A(addr1), .ADDR_B(18'h0), .ADDR_F(18'h0),
        .ACK(ack1), .RDATA(rdata1), .ROM_ADDR(rom_addr1),
        .ROM_CEn(cen1), .ROM_OEn(oen1), .ROM_DATA(rom_data1)
    );

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        oen_cnt <= rom_oen ? 0 : oen_cnt + 1;
    end

    // ROM data only valid in the last access cycle, so an early capture reads garbage.
    assign rom_data  = (!rom_cen && !rom_oen && oen_cnt == W - 1) ? rom_word(rom_addr) : 32'h0BAD_0BAD;
    assign rom_data1 = (!cen1 && !oen1) ? rom_word(rom_addr1) : 32'h0BAD_0BAD;

    initial begin : monitor
        logic prev_cen;
        int   cen_fall;
        int   run;
        exp_t e;
        prev_cen = 1'b1;
        cen_fall = 0;
        run      = 0;
        forever begin
            @(negedge clk);
            if (!rom_cen && prev_cen) cen_fall = cyc;
            prev_cen = rom_cen;
            if (!rom_cen && q.size() > 0) chk("rom_addr_stable", rom_addr, q[0].addr);
            if (!rom_oen) begin
                run++;
            end else begin
                if (run > 0 && q.size() > 0) chk("oen_low_cycles", run, W);
                run = 0;
            end
            if (ack != 3'b000) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got %b expected none", ack);
                end else begin
                    e = q.pop_front();
                    chk("ack", ack, e.ack);
                    chk("rdata", rdata, e.data);
                    chk("ack_after_setup", cyc - cen_fall, W + 1);
                    chk("strobes_in_done", {rom_cen, rom_oen}, 2'b11);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requesters drop their bit the cycle after ACK unless listed in rereq.
    task automatic run_acks(input int n, input logic [2:0] rereq, output int last_cyc);
        int got;
        int t;
        logic [2:0] a;
        got      = 0;
        t        = 0;
        last_cyc = -1;
        while (got < n && t < 200) begin
            @(negedge clk);
            t++;
            if (ack != 3'b000) begin
                got++;
                a        = ack;
                last_cyc = cyc;
                @(posedge clk);
                #1;
                req = req & ~(a & ~rereq);
            end
        end
        if (got < n) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: got %0d acks expected %0d", got, n);
        end
    endtask

    initial begin : stim
        int t0, ta, n_ack, lows, ta1;
        logic [2:0]  a1;
        logic [31:0] d1;
        rstn = 1'b0; req = 3'b000; addr_a = '0; addr_b = '0; addr_f = '0;
        req1 = 3'b000; addr1 = '0;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_cen", rom_cen, 1'b1);
        chk("reset_oen", rom_oen, 1'b1);
        chk("reset_ack", ack, 3'b000);
        chk("reset_rom_addr", rom_addr, 18'h0);
        chk("reset_rdata", rdata, 32'h0);
        tick();
        rstn = 1'b1;

        // single request from layer A
        addr_a = 18'h00001; req = 3'b001; t0 = cyc;
        expect_acc(3'b001, 18'h00001);
        run_acks(1, 3'b000, ta);
        chk("single_latency", ta - t0, W + 2);

        // reset during the second access cycle aborts the read
        addr_a = 18'h00005; req = 3'b001;
        repeat (3) tick();
        rstn = 1'b0; req = 3'b000;
        tick();
        @(negedge clk);
        chk("abort_cen", rom_cen, 1'b1);
        chk("abort_oen", rom_oen, 1'b1);
        chk("abort_ack", ack, 3'b000);
        tick();
        rstn = 1'b1;
        n_ack = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack != 3'b000) n_ack++;
        end
        chk("no_ack_after_abort", n_ack, 0);
        chk("rdata_after_abort", rdata, 32'h0);
        tick();

        // all three requesting
        addr_a = 18'h0000A; addr_b = 18'h00014; addr_f = 18'h0001E; req = 3'b111;
        expect_acc(3'b001, 18'h0000A);
        expect_acc(3'b010, 18'h00014);
        expect_acc(3'b100, 18'h0001E);
        run_acks(3, 3'b000, ta);
`ifndef GFX_ROM_ARB_RR_EN
        req = 3'b001;
        expect_acc(3'b001, 18'h0000A);
        run_acks(1, 3'b000, ta);
`endif

        // address change in flight must not reach the ROM
        addr_b = 18'h00002; req = 3'b010;
        expect_acc(3'b010, 18'h00002);
        repeat (3) tick();
        addr_b = 18'h00007;
        run_acks(1, 3'b000, ta);
        repeat (5) tick();
        chk("rdata_hold", rdata, rom_word(18'h00002));

        // single wait-cycle instance
        addr1 = 18'h00003; req1 = 3'b001; t0 = cyc;
        lows = 0; ta1 = -1; a1 = 3'b000; d1 = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!oen1) lows++;
            if (ack1 != 3'b000 && ta1 < 0) begin
                ta1 = cyc; a1 = ack1; d1 = rdata1;
                @(posedge clk);
                #1;
                req1 = 3'b000;
            end
        end
        chk("w1_oen_low_cycles", lows, 1);
        chk("w1_latency", ta1 - t0, 3);
        chk("w1_ack", a1, 3'b001);
        chk("w1_rdata", d1, rom_word(18'h00003));
        tick();

`ifdef GFX_ROM_ARB_RR_EN
        // A re-requests after every ACK; B and F must still be served
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        addr_a = 18'h00028; addr_b = 18'h00032; addr_f = 18'h0003C; req = 3'b111;
        expect_acc(3'b001, 18'h00028);
        expect_acc(3'b010, 18'h00032);
        expect_acc(3'b100, 18'h0003C);
        expect_acc(3'b001, 18'h00028);
        run_acks(4, 3'b001, ta);
        req = 3'b000;
`endif

        repeat (10) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
